// File: rtl/debug_uart_pkg.sv
// Shared types and constants for the debug UART transmitter.
// Frame length depends on the DEBUG_UART_CSUM_EN macro (checksum byte appended when defined).
package debug_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic [7:0] SYNC_BYTE        = 8'hA5;
  localparam int         NUM_PAYLOAD      = 7;
  localparam int         BITS_PER_BYTE    = 10;
  localparam int         FRAME_BYTES_BASE = NUM_PAYLOAD + 1;
  localparam int         FRAME_BYTES_CSUM = NUM_PAYLOAD + 2;

`ifdef DEBUG_UART_CSUM_EN
  localparam int FRAME_BYTES = FRAME_BYTES_CSUM;
`else
  localparam int FRAME_BYTES = FRAME_BYTES_BASE;
`endif

  // XOR of the payload bytes only; the sync byte never contributes.
  function automatic logic [7:0] xor_payload(input logic [NUM_PAYLOAD-1:0][7:0] p);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < NUM_PAYLOAD; i++) begin
      acc = acc ^ p[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/debug_uart_tx_byte.sv
// 8N1 byte serialiser: owns the 16-bit baud counter, bit counter and line register.
// Handshake: load is taken in IDLE, or in the cycle done=1 (last stop-bit cycle) so bytes chain with no gap;
// done is a one-cycle pulse marking the final clock of the stop bit.
module uart_tx_byte
  import debug_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        load,
  input  logic [7:0]  data,
  output logic        tx,
  output logic        done,
  output uart_state_e state
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] baud;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        bit_end;

  assign bit_end = (baud == BAUD_LAST);
  assign done    = (state == STOP) && bit_end;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (load) begin
            shreg <= data;
            baud  <= '0;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            state   <= DATA;
          end else begin
            baud <= baud + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (load) begin
              shreg <= data;
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/debug_uart_tx.sv
// Debug snapshot transmitter: on trigger, latches seven debug bytes and sends A5 + payload as 8N1.
// DEBUG_UART_CSUM_EN appends an XOR checksum byte of the payload.
module debug_uart_tx
  import debug_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       trigger,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  output logic       tx,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

  logic [NUM_PAYLOAD-1:0][7:0] snap;
  logic [3:0]  byte_idx;
  logic [3:0]  next_idx;
  logic [7:0]  next_byte;
  logic [7:0]  byte_data;
  logic        byte_load;
  logic        byte_done;
  logic        accept;
  logic        last_byte;
  uart_state_e byte_state;

  assign accept    = trigger && (byte_state == IDLE);
  assign last_byte = (byte_idx == LAST_IDX);
  assign next_idx  = byte_idx + 4'd1;

`ifdef DEBUG_UART_CSUM_EN
  logic [7:0] csum;
  assign csum = xor_payload(snap);
`endif

  always_comb begin
    next_byte = SYNC_BYTE;
    case (next_idx)
      4'd1: next_byte = snap[0];
      4'd2: next_byte = snap[1];
      4'd3: next_byte = snap[2];
      4'd4: next_byte = snap[3];
      4'd5: next_byte = snap[4];
      4'd6: next_byte = snap[5];
      4'd7: next_byte = snap[6];
`ifdef DEBUG_UART_CSUM_EN
      4'd8: next_byte = csum;
`endif
      default: next_byte = SYNC_BYTE;
    endcase
  end

  // Next byte is handed over on the last stop-bit cycle so the stream has no inter-byte gap.
  assign byte_load = accept || (byte_done && !last_byte);
  assign byte_data = accept ? SYNC_BYTE : next_byte;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      snap     <= '0;
      byte_idx <= '0;
      busy     <= 1'b0;
      drop_cnt <= 8'h00;
    end else begin
      if (accept) begin
        snap     <= {debug_port7, debug_port6, debug_port5, debug_port4,
                     debug_port3, debug_port2, debug_port1};
        byte_idx <= '0;
        busy     <= 1'b1;
      end else if (byte_done) begin
        if (last_byte) begin
          busy <= 1'b0;
        end else begin
          byte_idx <= next_idx;
        end
      end
      if (trigger && !accept && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk   (clk),
    .nreset(nreset),
    .load  (byte_load),
    .data  (byte_data),
    .tx    (tx),
    .done  (byte_done),
    .state (byte_state)
  );

endmodule

// File: tb/tb_debug_uart_tx.sv
// Bench for debug_uart_tx: serial decoder feeding a byte scoreboard plus cycle-exact boundary tests.
module tb_debug_uart_tx;
  import debug_uart_pkg::*;

  localparam int C         = 4;
  localparam int HALF      = C / 2;
  localparam int FRAME_CYC = FRAME_BYTES * BITS_PER_BYTE * C;

  logic       clk     = 1'b0;
  logic       nreset  = 1'b1;
  logic       trigger = 1'b0;
  logic [7:0] port [NUM_PAYLOAD];
  logic       tx;
  logic       busy;
  logic [7:0] drop_cnt;

  int         checks   = 0;
  int         errors   = 0;
  int         exp_drop = 0;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  debug_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .trigger    (trigger),
    .debug_port1(port[0]),
    .debug_port2(port[1]),
    .debug_port3(port[2]),
    .debug_port4(port[3]),
    .debug_port5(port[4]),
    .debug_port6(port[5]),
    .debug_port7(port[6]),
    .tx         (tx),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  // ---------------- serial decoder + scoreboard ----------------
  initial begin : rx_monitor
    bit         rx_active;
    int         rx_cnt;
    logic [7:0] rx_byte;
    logic [7:0] exp_b;
    rx_active = 1'b0;
    rx_cnt    = 0;
    rx_byte   = 8'h00;
    forever begin
      @(negedge clk);
      if (nreset !== 1'b1) begin
        rx_active = 1'b0;
      end else if (!rx_active) begin
        if (tx === 1'b0) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt == HALF) begin
          checks++;
          if (tx !== 1'b0) begin
            errors++;
            $display("FAIL rx_start got=%b want=0 t=%0t", tx, $time);
          end
        end
        if (rx_cnt >= HALF + C && rx_cnt <= HALF + 8 * C && ((rx_cnt - HALF) % C) == 0) begin
          rx_byte = {tx, rx_byte[7:1]};
        end
        if (rx_cnt == HALF + 9 * C) begin
          rx_active = 1'b0;
          checks++;
          if (tx !== 1'b1) begin
            errors++;
            $display("FAIL rx_stop got=%b want=1 t=%0t", tx, $time);
          end
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected got=%02h want=none t=%0t", rx_byte, $time);
          end else begin
            exp_b = exp_q.pop_front();
            if (rx_byte !== exp_b) begin
              errors++;
              $display("FAIL rx_byte got=%02h want=%02h t=%0t", rx_byte, exp_b, $time);
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame();
    logic [7:0] cs;
    cs = 8'h00;
    exp_q.push_back(SYNC_BYTE);
    for (int i = 0; i < NUM_PAYLOAD; i++) begin
      exp_q.push_back(port[i]);
      cs = cs ^ port[i];
    end
`ifdef DEBUG_UART_CSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  // Pulse trigger while idle; returns at the first negedge after the accepting edge.
  task automatic fire(input string name);
    @(negedge clk);
    trigger = 1'b1;
    push_frame();
    @(negedge clk);
    trigger = 1'b0;
    checks++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept got busy=%b tx=%b want busy=1 tx=0", name, busy, tx);
    end
  endtask

  task automatic wait_frame(input string name);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 2 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_done got busy=%b pending=%0d want busy=0 pending=0", name, busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 nreset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx, busy, drop_cnt} !== {1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_hold got tx=%b busy=%b drop=%02h want 1 0 00", tx, busy, drop_cnt);
    end
    nreset = 1'b1;
    repeat (100) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, drop_cnt} !== {1'b1, 1'b0, 8'h00}) begin
        errors++;
        $display("FAIL reset_idle got tx=%b busy=%b drop=%02h want 1 0 00", tx, busy, drop_cnt);
      end
    end
  endtask

  task automatic test_single_frame();
    int len;
    for (int i = 0; i < NUM_PAYLOAD; i++) port[i] = 8'(i + 1);
    fire("single");
    len = 1;
    while (busy === 1'b1 && len < FRAME_CYC + 50) begin
      @(negedge clk);
      if (busy === 1'b1) len++;
    end
    checks++;
    if (len != FRAME_CYC) begin
      errors++;
      $display("FAIL busy_len got=%0d want=%0d", len, FRAME_CYC);
    end
    wait_frame("single");
  endtask

  task automatic test_snapshot();
    for (int i = 0; i < NUM_PAYLOAD; i++) port[i] = 8'((i + 1) * 8'h11);
    fire("snapshot");
    for (int i = 0; i < NUM_PAYLOAD; i++) port[i] = 8'hFF;
    wait_frame("snapshot");
  endtask

  task automatic test_drop_boundary();
    for (int i = 0; i < NUM_PAYLOAD; i++) port[i] = 8'(8'h20 + i);
    fire("boundary");
    for (int i = 2; i <= FRAME_CYC; i++) @(negedge clk);
    // Final cycle of the last stop bit: still busy, so this trigger must be dropped.
    checks++;
    if (busy !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL last_stop got busy=%b tx=%b want busy=1 tx=1", busy, tx);
    end
    trigger = 1'b1;
    @(negedge clk);
    exp_drop++;
    checks++;
    if (busy !== 1'b0 || drop_cnt !== 8'(exp_drop)) begin
      errors++;
      $display("FAIL edge_drop got busy=%b drop=%02h want busy=0 drop=%02h", busy, drop_cnt, 8'(exp_drop));
    end
    for (int i = 0; i < NUM_PAYLOAD; i++) port[i] = 8'($urandom_range(0, 255));
    push_frame();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      errors++;
      $display("FAIL first_idle got busy=%b tx=%b want busy=1 tx=0", busy, tx);
    end
    repeat (300) @(negedge clk);
    trigger = 1'b0;
    exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
    @(negedge clk);
    checks++;
    if (drop_cnt !== 8'(exp_drop)) begin
      errors++;
      $display("FAIL drop_sat got=%02h want=%02h", drop_cnt, 8'(exp_drop));
    end
    wait_frame("drops");
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < NUM_PAYLOAD; i++) port[i] = 8'(8'h40 + i);
    fire("midreset");
    repeat (34 * C + 1) @(negedge clk);
    #2 nreset = 1'b0;
    #1;
    checks++;
    if ({tx, busy, drop_cnt} !== {1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL async_reset got tx=%b busy=%b drop=%02h want 1 0 00", tx, busy, drop_cnt);
    end
    exp_drop = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NUM_PAYLOAD; i++) port[i] = 8'(8'h60 + i);
    fire("after_reset");
    wait_frame("after_reset");
  endtask

  task automatic test_patterns();
    logic [7:0] pat [NUM_PAYLOAD];
    for (int i = 0; i < NUM_PAYLOAD; i++) pat[i] = 8'h00;
    pat[0] = 8'hFF;
    for (int i = 0; i < NUM_PAYLOAD; i++) port[i] = pat[i];
    fire("pattern_ff");
    wait_frame("pattern_ff");
    for (int i = 0; i < NUM_PAYLOAD; i++) port[i] = 8'(i + 1);
    fire("pattern_inc");
    wait_frame("pattern_inc");
  endtask

  task automatic test_back_to_back();
    int n;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NUM_PAYLOAD; i++) port[i] = 8'($urandom_range(0, 255));
      if (f == 0) begin
        fire("b2b");
      end else begin
        n = 0;
        while (busy === 1'b1 && n < FRAME_CYC + 10) begin
          @(negedge clk);
          n++;
        end
        trigger = 1'b1;
        push_frame();
        @(negedge clk);
        trigger = 1'b0;
        checks++;
        if (busy !== 1'b1 || tx !== 1'b0) begin
          errors++;
          $display("FAIL b2b_accept got busy=%b tx=%b want busy=1 tx=0", busy, tx);
        end
      end
    end
    wait_frame("b2b");
    checks++;
    if (drop_cnt !== 8'(exp_drop)) begin
      errors++;
      $display("FAIL b2b_drop got=%02h want=%02h", drop_cnt, 8'(exp_drop));
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < NUM_PAYLOAD; i++) port[i] = 8'h00;
    test_reset();
    test_single_frame();
    test_snapshot();
    test_drop_boundary();
    test_reset_mid_frame();
    test_patterns();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_uart_tx.md
# debug_uart_tx

Serial debug transmitter downstream of the CPU top: on each trigger it snapshots the seven 8-bit debug ports (instr addr, instr, rd addr, rd value, ALU out, writeback data, reset status) and ships them as a framed 8N1 UART byte stream to the host serial-port debugger. It is a pure consumer of the debug ports and never back-pressures the CPU. Triggers arriving mid-frame are dropped and counted.

## Interface
- CLKS_PER_BIT, default 16: clk cycles per UART bit; legal range 2..65535.
- clk  in  1  system clock; all state updates on rising edge.
- nreset  in  1  asynchronous, active-low reset.
- trigger  in  1  single-cycle pulse requesting a snapshot, typically asserted at the writeback phase.
- debug_port1..debug_port7  in  8 each  payload bytes, sampled only on an accepted trigger.
- tx  out  1  UART line; idle high.
- busy  out  1  high from the cycle after an accepted trigger until the frame's last stop bit ends.
- drop_cnt  out  8  saturating count of rejected triggers.

## Operation
- Frame: sync byte 0xA5, then debug_port1 through debug_port7 in order; with checksum enabled, one trailing byte follows (see Configuration). Base frame is 8 bytes.
- Byte format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). There is no gap between consecutive bytes.
- FSM states:
  - IDLE: tx=1, busy=0. When trigger=1, latch all 7 ports into a snapshot register, set byte_idx=0, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=byte[bit_idx] for CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - if byte_idx is the last index, go to IDLE;
    - otherwise increment byte_idx and go to START.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps on bit completion. It is 16 bits wide.
- Accept rule: a trigger is accepted only when the state is IDLE.
  - A trigger with state≠IDLE increments drop_cnt, which saturates at 0xFF and never wraps.
  - This includes a trigger in the final cycle of the last stop bit: busy is still 1 there, so the trigger is dropped.
- Snapshot isolation: changes on debug_port* after acceptance do not affect the frame in flight.
- Reset, including mid-frame, forces:
  - state=IDLE, tx=1, busy=0;
  - drop_cnt=0, all counters 0, snapshot 0.

## Timing
- Reset values: tx=1, busy=0, drop_cnt=0x00.
- Trigger accepted at edge T:
  - busy=1 and tx=0 (start bit) from T+1;
  - bit k of byte b begins at T+1+(b*10+1+k)*CLKS_PER_BIT.
- Frame length is N*10*CLKS_PER_BIT cycles, where N=8, or 9 with checksum.
  - busy falls at T+1+N*10*CLKS_PER_BIT.
  - A trigger on that same cycle is accepted.
- tx and busy are registered outputs with no combinational path from the inputs. drop_cnt updates the cycle after the rejected trigger.

## Configuration
- DEBUG_UART_CSUM_EN defined: a 9th byte is appended, equal to the XOR of the 7 payload bytes (the sync byte is excluded). N=9.
- DEBUG_UART_CSUM_EN undefined: N=8 and no checksum logic is present.

## Structure
- Shared package debug_uart_pkg holds:
  - FSM state encoding (IDLE, START, DATA, STOP);
  - SYNC_BYTE=8'hA5;
  - NUM_PAYLOAD=7;
  - frame-length constants for both configurations.
- Sub-module uart_tx_byte: serialises one byte with start and stop bits. It has a load/done handshake and owns the baud and bit counters. The top holds the snapshot, byte_idx sequencing, checksum and drop counter.

## Test plan
- Reset check, CLKS_PER_BIT=4: release nreset → tx=1, busy=0, drop_cnt=0 for 100 cycles with no trigger.
- Single frame: ports=01,02,..,07, then one trigger pulse.
  - Decoded bytes are A5 01 02 03 04 05 06 07.
  - busy is high for exactly 320 cycles.
- Snapshot isolation: trigger with ports=0x11..0x77, then change all ports to 0xFF on the next cycle → decoded payload is still 11..77.
- Drops and boundary:
  - 300 triggers during one frame → drop_cnt=0xFF (saturated);
  - trigger on the last stop-bit cycle → dropped;
  - trigger on the first cycle busy=0 → a new frame starts.
- Reset mid-frame: assert nreset=0 during byte 3 DATA → tx=1 and busy=0 immediately (asynchronous). After release, the next trigger yields a clean frame starting with A5.
- Checksum, with DEBUG_UART_CSUM_EN: ports=01..07 → 9th byte = 0x01^0x02^…^0x07 = 0x00; ports=FF,00,00,00,00,00,00 → 9th byte = 0xFF; busy is high for 360 cycles.
